// File: rtl/logic_op_pkg.sv
// Opcode encoding and per-bit logic function for the logic op unit.
// Pure types/functions: no latency, no flow control.
// Shared by the unit and anything that needs the op_e encoding.
package logic_op_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'b000,
        OP_OR     = 3'b001,
        OP_XOR    = 3'b010,
        OP_NOR    = 3'b011,
        OP_NAND   = 3'b100,
        OP_XNOR   = 3'b101,
        OP_NOT_A  = 3'b110,
        OP_PASS_A = 3'b111
    } op_e;

    // Single-bit form so callers of any width apply it bit by bit.
    function automatic logic logic_op_f(input op_e op, input logic a, input logic b);
        logic r;
        r = 1'b0;
        case (op)
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_NOR:    r = ~(a | b);
            OP_NAND:   r = ~(a & b);
            OP_XNOR:   r = ~(a ^ b);
            OP_NOT_A:  r = ~a;
            OP_PASS_A: r = a;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_op_skid.sv
// Generic 2-entry valid/ready skid buffer: main output register plus one skid slot.
// Latency: 1 cycle when the main register is empty or draining.
// Backpressure: in_rdy = ~skid_vld (registered); sustains 1 beat/cycle, strict order.
module logic_op_skid #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    logic         main_vld;
    logic [W-1:0] main_dat;
    logic         skid_vld;
    logic [W-1:0] skid_dat;
    logic         accept;
    logic         drain;

    assign accept  = in_vld & in_rdy;
    assign drain   = main_vld & out_rdy;
    assign in_rdy  = ~skid_vld;
    assign out_vld = main_vld;
    assign out_dat = main_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld <= 1'b0;
            main_dat <= '0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
        end else if (drain) begin
            if (skid_vld) begin
                // Older skid entry moves up; a new beat may refill the slot.
                main_dat <= skid_dat;
                if (accept) begin
                    skid_dat <= in_dat;
                end else begin
                    skid_vld <= 1'b0;
                end
            end else if (accept) begin
                main_dat <= in_dat;
            end else begin
                main_vld <= 1'b0;
            end
        end else if (accept) begin
            if (!main_vld) begin
                main_vld <= 1'b1;
                main_dat <= in_dat;
            end else begin
                skid_vld <= 1'b1;
                skid_dat <= in_dat;
            end
        end
    end

endmodule

// File: rtl/logic_op_unit.sv
// Registered bitwise logic unit with optional accumulator chaining and zero/parity flags.
// Latency: 1 cycle from accept to out_* when the output stage is empty or draining.
// Backpressure: 2-entry skid output; in_ready drops only once the skid slot holds a beat.
module logic_op_unit
    import logic_op_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       s,
    input  logic             acc_en,
    input  logic             acc_clr,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_par,
    output logic             out_valid,
    input  logic             out_ready
);

    op_e              op;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] eff_a;
    logic [WIDTH-1:0] res;
    logic             res_zero;
    logic             res_par;
    logic             accept;

    assign op     = op_e'(s);
    assign accept = in_valid & in_ready;
    // acc_clr with acc_en operates on the init value in the same beat.
    assign eff_a  = acc_en ? (acc_clr ? ACC_INIT : acc) : a;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign res[i] = logic_op_f(op, eff_a[i], b[i]);
    end

    assign res_zero = ~|res;
    assign res_par  = ^res;

    // Updated at accept so chained ops stay correct regardless of output stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= ACC_INIT;
        end else if (accept) begin
            acc <= res;
        end
    end

    logic_op_skid #(.W(WIDTH + 2)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_valid),
        .in_rdy  (in_ready),
        .in_dat  ({res_par, res_zero, res}),
        .out_vld (out_valid),
        .out_rdy (out_ready),
        .out_dat ({out_par, out_zero, out_data})
    );

endmodule

// File: tb/tb_logic_op_unit.sv
// Scoreboard bench for logic_op_unit: truth-table reference model, directed and random traffic.
module tb_logic_op_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] a, b;
    logic [2:0] s;
    logic       acc_en, acc_clr, in_valid, in_ready;
    logic [7:0] out_data;
    logic       out_zero, out_par, out_valid, out_ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];
    logic [7:0] macc;

    logic_op_unit #(.WIDTH(8), .ACC_INIT(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .s(s),
        .acc_en(acc_en), .acc_clr(acc_clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_zero(out_zero), .out_par(out_par),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Truth table per opcode, indexed by {a_bit, b_bit}.
    function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        logic [3:0] tt [8];
        logic [7:0] r;
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0001;
        tt[4] = 4'b0111; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;
        for (int i = 0; i < 8; i++) r[i] = tt[op][{x[i], y[i]}];
        return r;
    endfunction

    // Monitor: pops the scoreboard on each handshake away from the clock edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            obs_q.push_back({out_par, out_zero, out_data});
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {22'd0, out_par, out_zero, out_data}, 32'hFFFF_FFFF);
            end else begin
                chk("scoreboard", {22'd0, out_par, out_zero, out_data}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] ts,
                        input logic ten, input logic tclr);
        logic [7:0] ea, r;
        int n;
        a = ta; b = tb; s = ts; acc_en = ten; acc_clr = tclr; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            ea = ten ? (tclr ? 8'h00 : macc) : ta;
            r  = model(ts, ea, tb);
            macc = r;
            exp_q.push_back({^r, (r == 8'h00), r});
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        tick();
    endtask

    task automatic chk_obs(input string nm, input logic [7:0] v[], input int zero_idx);
        chk({nm, "_count"}, obs_q.size(), v.size());
        for (int i = 0; i < v.size() && i < obs_q.size(); i++) begin
            chk({nm, "_data"}, obs_q[i][7:0], v[i]);
            chk({nm, "_zero"}, obs_q[i][8], (i == zero_idx) ? 1 : 0);
        end
        obs_q.delete();
    endtask

    logic [7:0] t1[] = '{8'h30, 8'hFC, 8'hCC, 8'h03, 8'hCF, 8'h33, 8'h0F, 8'hF0};
    logic [7:0] t2[] = '{8'h00};
    logic [7:0] t3[] = '{8'h01, 8'h81, 8'h7E};
    logic [7:0] t5[] = '{8'h5A};
    bit rand_done;

    initial begin
        rst_n = 1'b0; a = '0; b = '0; s = '0; acc_en = 0; acc_clr = 0;
        in_valid = 0; out_ready = 0; macc = 8'h00;
        #23;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_par", out_par, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        // 1: every opcode back-to-back, 1-cycle latency
        out_ready = 1'b1;
        send(8'hF0, 8'h3C, 3'd0, 0, 0);
        chk("t1_latency_valid", out_valid, 1);
        chk("t1_latency_data", out_data, 8'h30);
        for (int op = 1; op < 8; op++) send(8'hF0, 8'h3C, op[2:0], 0, 0);
        wait_empty();
        for (int i = 0; i < obs_q.size(); i++) chk("t1_par", obs_q[i][9], 0);
        chk_obs("t1", t1, -1);

        // 2: XOR to zero
        send(8'hAA, 8'hAA, 3'd2, 0, 0);
        wait_empty();
        if (obs_q.size() > 0) chk("t2_par", obs_q[0][9], 0);
        chk_obs("t2", t2, 0);

        // 3: accumulator chain
        send(8'h55, 8'h01, 3'd1, 1, 1);
        send(8'h55, 8'h80, 3'd1, 1, 0);
        send(8'h55, 8'hFF, 3'd2, 1, 0);
        wait_empty();
        chk_obs("t3", t3, -1);

        // 4: backpressure fills main and skid, third beat waits
        out_ready = 1'b0;
        send(8'h11, 8'h0F, 3'd0, 0, 0);
        chk("t4_rdy_after1", in_ready, 1);
        send(8'h22, 8'h0F, 3'd1, 0, 0);
        chk("t4_rdy_after2", in_ready, 0);
        a = 8'h33; b = 8'h0F; s = 3'd2; acc_en = 0; acc_clr = 0; in_valid = 1'b1;
        chk("t4_hold_data", out_data, 8'h01);
        tick();
        chk("t4_still_blocked", in_ready, 0);
        chk("t4_stable_data", out_data, 8'h01);
        out_ready = 1'b1;
        tick();
        chk("t4_rdy_freed", in_ready, 1);
        send(8'h33, 8'h0F, 3'd2, 0, 0);
        begin
            int c0;
            c0 = cyc;
            for (int i = 0; i < 6; i++) send(8'(i * 37), 8'(i * 91), 3'(i), 0, 0);
            chk("t4_throughput", cyc - c0, 6);
        end
        wait_empty();
        obs_q.delete();

        // 5: asynchronous reset with skid full
        out_ready = 1'b0;
        send(8'h0F, 8'hF0, 3'd1, 1, 0);
        send(8'h0F, 8'hF0, 3'd2, 1, 0);
        chk("t5_skid_full", in_ready, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_ready", in_ready, 1);
        exp_q.delete();
        obs_q.delete();
        macc = 8'h00;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        send(8'hFF, 8'h5A, 3'd1, 1, 0);
        wait_empty();
        chk_obs("t5", t5, -1);

        // 6: random traffic under random backpressure
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    send(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        out_ready = 1'b1;
        wait_empty();
        chk("t6_beats", obs_q.size(), 10000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
